// File: rtl/tiny_pkg.sv
// Shared types and helpers for the tiny_merger 2:1 write-stream merger.
package tiny_pkg;

   localparam int unsigned DEF_DATA_W = 32;
   localparam int unsigned DEF_ADDR_W = 32;

   typedef enum logic {
      IDLE    = 1'b0,
      WR_DATA = 1'b1
   } master_state;

   typedef enum logic {
      SRC_M1 = 1'b0,
      SRC_M2 = 1'b1
   } src_id_t;

   // One-hot grant {m2, m1} to source id; an empty grant maps to m1.
   function automatic src_id_t gnt_to_src(input logic [1:0] gnt);
      return gnt[1] ? SRC_M2 : SRC_M1;
   endfunction

endpackage

// File: rtl/tiny_merger_if.sv
// Bundle of the two initiator ports and the downstream port of tiny_merger.
interface tiny_merger_if
   import tiny_pkg::*;
#(
   parameter int unsigned DATA_W = DEF_DATA_W,
   parameter int unsigned ADDR_W = DEF_ADDR_W
);

   logic              m1_valid;
   logic              m1_ready;
   logic [DATA_W-1:0] m1_data;
   logic [ADDR_W-1:0] m1_addr;

   logic              m2_valid;
   logic              m2_ready;
   logic [DATA_W-1:0] m2_data;
   logic [ADDR_W-1:0] m2_addr;

   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;
   logic [ADDR_W-1:0] s_addr;
   logic              s_src;

   // Merger side: consumes initiator beats, produces the downstream beat.
   modport slave (
      input  m1_valid, m1_data, m1_addr,
      output m1_ready,
      input  m2_valid, m2_data, m2_addr,
      output m2_ready,
      output s_valid, s_data, s_addr, s_src,
      input  s_ready
   );

   // Environment side: drives initiators and the downstream ready.
   modport master (
      output m1_valid, m1_data, m1_addr,
      input  m1_ready,
      output m2_valid, m2_data, m2_addr,
      input  m2_ready,
      input  s_valid, s_data, s_addr, s_src,
      output s_ready
   );

endinterface

// File: rtl/tiny_rr_arb2.sv
// Two-requester arbiter: round-robin or fixed m1 priority on contention.
module tiny_rr_arb2
   import tiny_pkg::*;
#(
   parameter bit FAIR_RR = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] gnt
);

   src_id_t last_grant;

   // Only a completed accept moves the round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_grant <= SRC_M2;
      end else if (advance) begin
         last_grant <= gnt_to_src(gnt);
      end
   end

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (FAIR_RR && (last_grant == SRC_M1)) ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/tiny_merger.sv
// 2:1 write-stream merger with a one-beat registered output buffer.
module tiny_merger
   import tiny_pkg::*;
#(
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned ADDR_W  = DEF_ADDR_W,
   parameter bit          FAIR_RR = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   tiny_merger_if.slave  bus
);

   master_state       state;
   logic [DATA_W-1:0] buf_data;
   logic [ADDR_W-1:0] buf_addr;
   src_id_t           buf_src;

   logic [1:0]        req;
   logic [1:0]        gnt;
   logic              can_load;
   logic              accept;

   assign req = {bus.m2_valid, bus.m1_valid};

   // Buffer can take a beat when empty or when its beat leaves this cycle.
   assign can_load = rst_n & ((state == IDLE) | ((state == WR_DATA) & bus.s_ready));
   assign accept   = can_load & (|req);

   tiny_rr_arb2 #(
      .FAIR_RR (FAIR_RR)
   ) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .advance (accept),
      .gnt     (gnt)
   );

   assign bus.m1_ready = can_load & gnt[0];
   assign bus.m2_ready = can_load & gnt[1];

   // Output buffer and IDLE/WR_DATA state; accept wins over drain for back-to-back.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         buf_data <= '0;
         buf_addr <= '0;
         buf_src  <= SRC_M1;
      end else if (accept) begin
         state    <= WR_DATA;
         buf_src  <= gnt_to_src(gnt);
         if (gnt[1]) begin
            buf_data <= bus.m2_data;
            buf_addr <= bus.m2_addr;
         end else begin
            buf_data <= bus.m1_data;
            buf_addr <= bus.m1_addr;
         end
      end else if ((state == WR_DATA) && bus.s_ready) begin
         state <= IDLE;
      end
   end

   assign bus.s_valid = (state == WR_DATA);
   assign bus.s_data  = buf_data;
   assign bus.s_addr  = buf_addr;
   assign bus.s_src   = 1'(buf_src);

endmodule

// File: tb/tb_tiny_merger.sv
// Self-checking bench for tiny_merger: round-robin and fixed-priority instances.
module tb_tiny_merger;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 32;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   tiny_merger_if #(.DATA_W(DW), .ADDR_W(AW)) bus_rr ();
   tiny_merger_if #(.DATA_W(DW), .ADDR_W(AW)) bus_fp ();

   tiny_merger #(.DATA_W(DW), .ADDR_W(AW), .FAIR_RR(1'b1)) dut_rr (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_rr)
   );

   tiny_merger #(.DATA_W(DW), .ADDR_W(AW), .FAIR_RR(1'b0)) dut_fp (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_fp)
   );

   // Stimulus per instance: index 0 = round-robin, 1 = fixed priority.
   logic        v1[2], v2[2], sr[2];
   logic [31:0] d1[2], a1[2], d2[2], a2[2];
   logic        o_r1[2], o_r2[2], o_sv[2], o_src[2];
   logic [31:0] o_sd[2], o_sa[2];

   // Reference model: buffer occupancy, its beat, and last winner (1 = m1, 2 = m2).
   bit          mb_busy[2];
   logic [31:0] mb_data[2], mb_addr[2];
   int          mb_src[2];
   int          m_last[2];
   bit          fair[2];
   logic [63:0] sbq[4][$];

   int n_checks = 0;
   int n_pass   = 0;
   bit keep_valid = 1'b0;
   int exp_rr[4];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
   endtask

   task automatic drive();
      bus_rr.m1_valid = v1[0]; bus_rr.m1_data = d1[0]; bus_rr.m1_addr = a1[0];
      bus_rr.m2_valid = v2[0]; bus_rr.m2_data = d2[0]; bus_rr.m2_addr = a2[0];
      bus_rr.s_ready  = sr[0];
      bus_fp.m1_valid = v1[1]; bus_fp.m1_data = d1[1]; bus_fp.m1_addr = a1[1];
      bus_fp.m2_valid = v2[1]; bus_fp.m2_data = d2[1]; bus_fp.m2_addr = a2[1];
      bus_fp.s_ready  = sr[1];
   endtask

   task automatic sample();
      o_r1[0] = bus_rr.m1_ready; o_r2[0] = bus_rr.m2_ready; o_sv[0] = bus_rr.s_valid;
      o_sd[0] = bus_rr.s_data;   o_sa[0] = bus_rr.s_addr;   o_src[0] = bus_rr.s_src;
      o_r1[1] = bus_fp.m1_ready; o_r2[1] = bus_fp.m2_ready; o_sv[1] = bus_fp.s_valid;
      o_sd[1] = bus_fp.s_data;   o_sa[1] = bus_fp.s_addr;   o_src[1] = bus_fp.s_src;
   endtask

   task automatic new_beat(input int d, input int p);
      if (p == 1) begin
         v1[d] = 1'b1; d1[d] = $urandom; a1[d] = $urandom;
      end else begin
         v2[d] = 1'b1; d2[d] = $urandom; a2[d] = $urandom;
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         mb_busy[d] = 1'b0; mb_data[d] = '0; mb_addr[d] = '0;
         mb_src[d] = 1; m_last[d] = 2;
      end
      for (int i = 0; i < 4; i++) sbq[i].delete();
   endtask

   function automatic int winner(input int d);
      if (v1[d] && v2[d]) return fair[d] ? ((m_last[d] == 2) ? 1 : 2) : 1;
      if (v1[d]) return 1;
      if (v2[d]) return 2;
      return 0;
   endfunction

   // One clock: drive, check against the model, advance model and initiators.
   task automatic step();
      int          w;
      bit          cl;
      int          idx;
      logic [63:0] got;
      drive();
      #1;
      sample();
      for (int d = 0; d < 2; d++) begin
         w  = winner(d);
         cl = !mb_busy[d] || sr[d];
         check($sformatf("m1_ready[%0d]", d), 64'(o_r1[d]), 64'(cl && (w == 1)));
         check($sformatf("m2_ready[%0d]", d), 64'(o_r2[d]), 64'(cl && (w == 2)));
         check($sformatf("one_ready[%0d]", d), 64'(o_r1[d] & o_r2[d]), 64'd0);
         check($sformatf("s_valid[%0d]", d), 64'(o_sv[d]), 64'(mb_busy[d]));
         if (mb_busy[d]) begin
            check($sformatf("s_data[%0d]", d), 64'(o_sd[d]), 64'(mb_data[d]));
            check($sformatf("s_addr[%0d]", d), 64'(o_sa[d]), 64'(mb_addr[d]));
            check($sformatf("s_src[%0d]", d), 64'(o_src[d]), 64'(mb_src[d] - 1));
         end
         if (mb_busy[d] && sr[d] && o_sv[d]) begin
            idx = d * 2 + int'(o_src[d]);
            check($sformatf("sb_pending[%0d]", d), 64'(sbq[idx].size() != 0), 64'd1);
            if (sbq[idx].size() != 0) begin
               got = sbq[idx].pop_front();
               check($sformatf("sb_order[%0d]", d), {o_sa[d], o_sd[d]}, got);
            end
         end
         if (cl && (w != 0)) begin
            mb_busy[d] = 1'b1;
            mb_src[d]  = w;
            m_last[d]  = w;
            mb_data[d] = (w == 1) ? d1[d] : d2[d];
            mb_addr[d] = (w == 1) ? a1[d] : a2[d];
            sbq[d * 2 + w - 1].push_back({mb_addr[d], mb_data[d]});
         end else if (mb_busy[d] && sr[d]) begin
            mb_busy[d] = 1'b0;
         end
      end
      for (int d = 0; d < 2; d++) begin
         if (v1[d] && o_r1[d]) begin
            if (keep_valid) new_beat(d, 1); else v1[d] = 1'b0;
         end
         if (v2[d] && o_r2[d]) begin
            if (keep_valid) new_beat(d, 2); else v2[d] = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_all(input logic nv1, input logic nv2, input logic nsr);
      for (int d = 0; d < 2; d++) begin
         v1[d] = nv1; v2[d] = nv2; sr[d] = nsr;
      end
   endtask

   initial begin
      fair[0] = 1'b1; fair[1] = 1'b0;
      exp_rr = '{0, 1, 0, 1};
      for (int d = 0; d < 2; d++) begin
         d1[d] = '0; a1[d] = '0; d2[d] = '0; a2[d] = '0;
      end
      model_reset();

      // Reset: outputs cleared, readies low even with requests present.
      rst_n = 1'b0;
      set_all(1'b1, 1'b1, 1'b1);
      drive();
      #1;
      sample();
      for (int d = 0; d < 2; d++) begin
         check($sformatf("rst_s_valid[%0d]", d), 64'(o_sv[d]), 64'd0);
         check($sformatf("rst_s_data[%0d]", d), 64'(o_sd[d]), 64'd0);
         check($sformatf("rst_s_addr[%0d]", d), 64'(o_sa[d]), 64'd0);
         check($sformatf("rst_s_src[%0d]", d), 64'(o_src[d]), 64'd0);
         check($sformatf("rst_m1_ready[%0d]", d), 64'(o_r1[d]), 64'd0);
         check($sformatf("rst_m2_ready[%0d]", d), 64'(o_r2[d]), 64'd0);
      end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();

      // Contention with both initiators streaming, s_ready high.
      keep_valid = 1'b1;
      for (int d = 0; d < 2; d++) begin
         new_beat(d, 1);
         new_beat(d, 2);
         sr[d] = 1'b1;
      end
      for (int k = 0; k < 5; k++) begin
         step();
         if (k >= 1) begin
            check("rr_no_bubble", 64'(o_sv[0]), 64'd1);
            check("rr_src_seq", 64'(o_src[0]), 64'(exp_rr[k - 1]));
            check("fp_src_seq", 64'(o_src[1]), 64'd0);
         end
         check("fp_m2_ready_low", 64'(o_r2[1]), 64'd0);
      end
      keep_valid = 1'b0;
      set_all(1'b0, 1'b0, 1'b1);
      repeat (2) step();

      // Single m1 beat.
      for (int d = 0; d < 2; d++) begin
         v1[d] = 1'b1; d1[d] = 32'hA5A5_0001; a1[d] = 32'h0000_0010;
      end
      step();
      check("single_m1_ready", 64'(o_r1[0]), 64'd1);
      step();
      check("single_s_valid", 64'(o_sv[0]), 64'd1);
      check("single_s_src", 64'(o_src[0]), 64'd0);
      check("single_s_data", 64'(o_sd[0]), 64'hA5A5_0001);
      check("single_s_addr", 64'(o_sa[0]), 64'h0000_0010);
      step();

      // Backpressure: buffered m1 beat, m2 waiting, s_ready low for 5 cycles.
      for (int d = 0; d < 2; d++) begin
         v1[d] = 1'b1; d1[d] = 32'h1234_5678; a1[d] = 32'h0000_0020;
      end
      step();
      for (int d = 0; d < 2; d++) begin
         new_beat(d, 2);
         sr[d] = 1'b0;
      end
      repeat (5) begin
         step();
         check("bp_s_valid", 64'(o_sv[0]), 64'd1);
         check("bp_s_data", 64'(o_sd[0]), 64'h1234_5678);
         check("bp_m2_ready", 64'(o_r2[0]), 64'd0);
      end
      set_all(1'b0, 1'b1, 1'b1);
      step();
      check("bp_release_m2_ready", 64'(o_r2[0]), 64'd1);
      repeat (2) step();

      // Reset while a beat is buffered.
      for (int d = 0; d < 2; d++) begin
         new_beat(d, 1);
         new_beat(d, 2);
         sr[d] = 1'b0;
      end
      step();
      step();
      check("pre_rst_s_valid", 64'(o_sv[0]), 64'd1);
      set_all(1'b1, 1'b1, 1'b0);
      rst_n = 1'b0;
      drive();
      #1;
      sample();
      check("mid_rst_s_valid_rr", 64'(o_sv[0]), 64'd0);
      check("mid_rst_s_valid_fp", 64'(o_sv[1]), 64'd0);
      check("mid_rst_m1_ready", 64'(o_r1[0]), 64'd0);
      check("mid_rst_m2_ready", 64'(o_r2[0]), 64'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      set_all(1'b1, 1'b1, 1'b1);
      step();
      check("post_rst_tie_m1", 64'(o_r1[0]), 64'd1);
      set_all(1'b0, 1'b0, 1'b1);
      repeat (3) step();

      // Randomized traffic; initiators hold each beat until accepted.
      for (int c = 0; c < 10000; c++) begin
         for (int d = 0; d < 2; d++) begin
            if (!v1[d] && ($urandom_range(0, 1) == 1)) new_beat(d, 1);
            if (!v2[d] && ($urandom_range(0, 1) == 1)) new_beat(d, 2);
            sr[d] = ($urandom_range(0, 3) != 0);
         end
         step();
      end
      // Drain; in-flight beats from the last random cycle still have to appear.
      for (int d = 0; d < 2; d++) sr[d] = 1'b1;
      for (int k = 0; k < 400; k++) begin
         if (!(v1[0] || v2[0] || v1[1] || v2[1])) break;
         step();
      end
      set_all(1'b0, 1'b0, 1'b1);
      repeat (3) step();
      for (int i = 0; i < 4; i++) begin
         check($sformatf("sb_drained[%0d]", i), 64'(sbq[i].size()), 64'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
